ras_controller: RTL

- Speculative Return Address Stack (RAS) storage and sequencing for the IF stage.
- Consumes the per-instruction call/return/coroutine classification from IF and updates a circular stack each cycle.
- Supplies a same-cycle predicted return target to the branch-prediction next-PC mux.
- Exports a checkpoint with every prediction; accepts a restore from the backend on misprediction flush, repairing pointer, occupancy and top entry.

---
 rtl/ras_controller.sv | 109 ++++++++++
 1 files changed

// File: rtl/ras_controller.sv
// Speculative return address stack for the IF stage: circular storage with
// same-cycle prediction, per-cycle checkpoint export and backend restore.
module ras_controller #(
  parameter  int DEPTH = 8,
  parameter  int XLEN  = 32,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_stall,
  input  logic             i_is_call,
  input  logic             i_is_return,
  input  logic             i_is_coroutine,
  input  logic [XLEN-1:0]  i_link_addr,
  output logic             o_predict_valid,
  output logic [XLEN-1:0]  o_predict_target,
  output logic [PTR_W-1:0] o_ckpt_tos,
  output logic [CNT_W-1:0] o_ckpt_count,
  output logic [XLEN-1:0]  o_ckpt_top,
  input  logic             i_restore_valid,
  input  logic [PTR_W-1:0] i_restore_tos,
  input  logic [CNT_W-1:0] i_restore_count,
  input  logic [XLEN-1:0]  i_restore_top
);

  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [XLEN-1:0]  r_mem [DEPTH];
  logic [PTR_W-1:0] r_tos;
  logic [CNT_W-1:0] r_count;

  logic [XLEN-1:0]  w_top;
  logic             w_empty;
  logic [PTR_W-1:0] w_tos_inc;
  logic [PTR_W-1:0] w_tos_dec;
  logic [CNT_W-1:0] w_count_sat_inc;

  logic [PTR_W-1:0] w_nxt_tos;
  logic [CNT_W-1:0] w_nxt_count;
  logic             w_wr_en;
  logic [PTR_W-1:0] w_wr_idx;
  logic [XLEN-1:0]  w_wr_data;

  assign w_top           = r_mem[r_tos];
  assign w_empty         = (r_count == '0);
  assign w_tos_inc       = r_tos + PTR_W'(1);
  assign w_tos_dec       = r_tos - PTR_W'(1);
  assign w_count_sat_inc = (r_count == FULL) ? FULL : r_count + CNT_W'(1);

  assign o_predict_target = w_top;
  assign o_ckpt_tos       = r_tos;
  assign o_ckpt_count     = r_count;
  assign o_ckpt_top       = w_top;
  assign o_predict_valid  = (i_is_return | i_is_coroutine) & ~w_empty
                            & ~i_stall & ~i_restore_valid;

  // Restore beats stall beats coroutine beats return beats call.
  always_comb begin
    w_nxt_tos   = r_tos;
    w_nxt_count = r_count;
    w_wr_en     = 1'b0;
    w_wr_idx    = r_tos;
    w_wr_data   = i_link_addr;
    if (i_restore_valid) begin
      w_nxt_tos   = i_restore_tos;
      w_nxt_count = i_restore_count;
      w_wr_en     = (i_restore_count != '0);
      w_wr_idx    = i_restore_tos;
      w_wr_data   = i_restore_top;
    end else if (i_stall) begin
      w_wr_en = 1'b0;
    end else if (i_is_coroutine) begin
      if (!w_empty) begin
        w_wr_en  = 1'b1;
        w_wr_idx = r_tos;
      end else begin
        w_nxt_tos   = w_tos_inc;
        w_nxt_count = w_count_sat_inc;
        w_wr_en     = 1'b1;
        w_wr_idx    = w_tos_inc;
      end
    end else if (i_is_return) begin
      if (!w_empty) begin
        w_nxt_tos   = w_tos_dec;
        w_nxt_count = r_count - CNT_W'(1);
      end
    end else if (i_is_call) begin
      // A push when full lands on the oldest slot; count just saturates.
      w_nxt_tos   = w_tos_inc;
      w_nxt_count = w_count_sat_inc;
      w_wr_en     = 1'b1;
      w_wr_idx    = w_tos_inc;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_tos   <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      r_tos   <= w_nxt_tos;
      r_count <= w_nxt_count;
      if (w_wr_en) r_mem[w_wr_idx] <= w_wr_data;
    end
  end

endmodule
